// File: rtl/rst_clken_pkg.sv
// Shared types and constants for the reset sequencer / clock-enable generator.
package rst_clken_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_DIV_W       = 16;
  localparam int unsigned DEF_RST_CYCLES  = 11;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // A divisor of 0 behaves exactly like 1.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/rst_clken_gen_ch.sv
// One divider channel: shadow divisor, period counter, strobe and toggle outputs.
module clken_div_ch
  import rst_clken_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             run_i,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             stb_o,
  output logic             tgl_o
);

  logic             act_q, act_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             stb_q, stb_d;
  logic             tgl_q, tgl_d;
  logic [DIV_W-1:0] last_c;

  assign last_c = DIV_W'(eff_div(32'(shadow_q)) - 32'd1);

  // A channel (re)starts on the first active edge or a resync; the divisor is
  // re-sampled only at period boundaries so mid-period changes wait their turn.
  always_comb begin
    act_d    = act_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    stb_d    = 1'b0;
    tgl_d    = tgl_q;
    if (!(run_i && en_i)) begin
      act_d = 1'b0;
      cnt_d = '0;
      tgl_d = 1'b0;
    end else if (!act_q || sync_clr_i) begin
      act_d    = 1'b1;
      shadow_d = div_i;
      cnt_d    = '0;
      tgl_d    = 1'b0;
    end else if (cnt_q == last_c) begin
      shadow_d = div_i;
      cnt_d    = '0;
      stb_d    = 1'b1;
      tgl_d    = ~tgl_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      act_q    <= 1'b0;
      shadow_q <= '0;
      cnt_q    <= '0;
      stb_q    <= 1'b0;
      tgl_q    <= 1'b0;
    end else begin
      act_q    <= act_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      stb_q    <= stb_d;
      tgl_q    <= tgl_d;
    end
  end

  assign stb_o = stb_q;
  assign tgl_o = tgl_q;

endmodule

// File: rtl/rst_clken_gen.sv
// Reset sequencer (release synchroniser + hold counter) driving N_CH clock-enable channels.
module rst_clken_gen
  import rst_clken_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  sw_rst_i,
  input  logic                  sync_i,
  input  logic [N_CH-1:0]       ch_en_i,
  input  logic [N_CH*DIV_W-1:0] div_i,
  output logic                  res_o,
  output logic                  res_n_o,
  output logic                  run_o,
  output logic [N_CH-1:0]       stb_o,
  output logic [N_CH-1:0]       tgl_o
);

  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned SW    = SYNC_STAGES - 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0]    sync_q;
  logic             res_q, res_n_q, run_q;
  logic             run_d;
  logic             sync_clr_c;

  // Leading synchroniser stages; the state register leaving HOLD acts as the final stage.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= SW'({sync_q, 1'b1});
    end
  end

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      HOLD: begin
        if (sync_q[SW-1]) begin
          state_d   = COUNT;
          rst_cnt_d = '0;
        end
      end
      COUNT: begin
        if (sw_rst_i) begin
          rst_cnt_d = '0;
        end else if (rst_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d   = RUN;
          rst_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (sw_rst_i) begin
          state_d   = COUNT;
          rst_cnt_d = '0;
        end
      end
      default: begin
        state_d   = HOLD;
        rst_cnt_d = '0;
      end
    endcase
  end

  assign run_d      = (state_d == RUN);
  assign sync_clr_c = sync_i && (state_q == RUN);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= HOLD;
      rst_cnt_q <= '0;
      res_q     <= 1'b1;
      res_n_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      res_q     <= ~run_d;
      res_n_q   <= run_d;
      run_q     <= run_d;
    end
  end

  assign res_o   = res_q;
  assign res_n_o = res_n_q;
  assign run_o   = run_q;

  for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
    clken_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk       (clk),
      .res_n     (res_n),
      .run_i     (run_d),
      .en_i      (ch_en_i[k]),
      .sync_clr_i(sync_clr_c),
      .div_i     (div_i[k*DIV_W +: DIV_W]),
      .stb_o     (stb_o[k]),
      .tgl_o     (tgl_o[k])
    );
  end

endmodule

// File: tb/tb_rst_clken_gen.sv
// Directed bench for rst_clken_gen: reset sequence, dividers, resync, soft and hard reset.
module tb_rst_clken_gen;

  logic        clk;
  logic        res_n;
  logic        sw_rst_i;
  logic        sync_i;
  logic [3:0]  ch_en_i;
  logic [63:0] div_i;
  logic        res_o;
  logic        res_n_o;
  logic        run_o;
  logic [3:0]  stb_o;
  logic [3:0]  tgl_o;

  int errors = 0;
  int checks = 0;

  rst_clken_gen #(
    .N_CH(4), .DIV_W(16), .RST_CYCLES(11), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .res_n(res_n), .sw_rst_i(sw_rst_i), .sync_i(sync_i),
    .ch_en_i(ch_en_i), .div_i(div_i), .res_o(res_o), .res_n_o(res_n_o),
    .run_o(run_o), .stb_o(stb_o), .tgl_o(tgl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_div(input int k, input logic [15:0] d);
    div_i[k*16 +: 16] = d;
  endtask

  // Release reset between edges and check the 12 hold edges plus the RUN entry edge.
  task automatic release_and_check(input string tag);
    logic [5:0] got;
    res_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      checks++;
      if ({res_o, res_n_o, run_o, stb_o} !== {3'b100, 4'b0000}) begin
        errors++;
        $display("FAIL %s_hold edge=%0d got res/res_n/run/stb=%b/%b/%b/%b expected 1/0/0/0000",
                 tag, e, res_o, res_n_o, run_o, stb_o);
      end
    end
    step(1);
    got = {res_o, res_n_o, run_o, stb_o[2:0]};
    checks++;
    if ({res_o, res_n_o, run_o, stb_o, tgl_o} !== 11'b011_0000_0000) begin
      errors++;
      $display("FAIL %s_run_entry got res/res_n/run/stb/tgl=%b/%b/%b/%b/%b expected 0/1/1/0000/0000",
               tag, res_o, res_n_o, run_o, stb_o, tgl_o);
    end
  endtask

  task automatic test_reset();
    res_n    = 1'b0;
    sw_rst_i = 1'b0;
    sync_i   = 1'b0;
    ch_en_i  = 4'hF;
    div_i    = '0;
    set_div(0, 16'd1);
    set_div(1, 16'd4);
    set_div(2, 16'd0);
    set_div(3, 16'd3);
    step(3);
    checks++;
    if ({res_o, res_n_o, run_o, stb_o, tgl_o} !== 11'b100_0000_0000) begin
      errors++;
      $display("FAIL reset_values got res/res_n/run/stb/tgl=%b/%b/%b/%b/%b expected 1/0/0/0000/0000",
               res_o, res_n_o, run_o, stb_o, tgl_o);
    end
    release_and_check("por");
  endtask

  task automatic test_divide();
    logic [3:0] es, et;
    for (int e = 1; e <= 12; e++) begin
      step(1);
      es = {(e % 3 == 0), 1'b1, (e % 4 == 0), 1'b1};
      et = {1'((e / 3) % 2), 1'(e % 2), 1'((e / 4) % 2), 1'(e % 2)};
      checks++;
      if (stb_o !== es || tgl_o !== et) begin
        errors++;
        $display("FAIL divide edge=%0d got stb/tgl=%b/%b expected %b/%b", e, stb_o, tgl_o, es, et);
      end
    end
  endtask

  task automatic test_div_change();
    logic exp;
    step(2);
    set_div(1, 16'd6);
    for (int r = 3; r <= 16; r++) begin
      step(1);
      exp = (r == 4) || (r == 10) || (r == 16);
      checks++;
      if (stb_o[1] !== exp) begin
        errors++;
        $display("FAIL div_change rel=%0d got stb1=%b expected %b", r, stb_o[1], exp);
      end
    end
  endtask

  task automatic test_sync();
    logic es, et;
    set_div(1, 16'd4);
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    checks++;
    if (stb_o !== 4'b0000 || tgl_o !== 4'b0000) begin
      errors++;
      $display("FAIL sync_clear got stb/tgl=%b/%b expected 0000/0000", stb_o, tgl_o);
    end
    for (int e = 1; e <= 16; e++) begin
      if (e == 7) sync_i = 1'b1;
      step(1);
      sync_i = 1'b0;
      es = (e == 4) || (e == 11) || (e == 15);
      et = (e >= 4 && e < 7) || (e >= 11 && e < 15);
      checks++;
      if (stb_o[1] !== es || tgl_o[1] !== et) begin
        errors++;
        $display("FAIL sync_ch1 edge=%0d got stb1/tgl1=%b/%b expected %b/%b",
                 e, stb_o[1], tgl_o[1], es, et);
      end
      if (e == 7) begin
        checks++;
        if (stb_o !== 4'b0000 || tgl_o !== 4'b0000) begin
          errors++;
          $display("FAIL sync_mid got stb/tgl=%b/%b expected 0000/0000", stb_o, tgl_o);
        end
      end
    end
  endtask

  task automatic test_sw_rst();
    sw_rst_i = 1'b1;
    step(1);
    sw_rst_i = 1'b0;
    checks++;
    if ({res_o, res_n_o, run_o, stb_o, tgl_o} !== 11'b100_0000_0000) begin
      errors++;
      $display("FAIL sw_rst_assert got res/res_n/run/stb/tgl=%b/%b/%b/%b/%b expected 1/0/0/0000/0000",
               res_o, res_n_o, run_o, stb_o, tgl_o);
    end
    step(10);
    checks++;
    if (res_o !== 1'b1 || run_o !== 1'b0) begin
      errors++;
      $display("FAIL sw_rst_hold got res/run=%b/%b expected 1/0", res_o, run_o);
    end
    step(1);
    checks++;
    if ({res_o, res_n_o, run_o, stb_o} !== 7'b011_0000) begin
      errors++;
      $display("FAIL sw_rst_release got res/res_n/run/stb=%b/%b/%b/%b expected 0/1/1/0000",
               res_o, res_n_o, run_o, stb_o);
    end
    step(3);
    checks++;
    if (stb_o !== 4'b1101) begin
      errors++;
      $display("FAIL sw_rst_restart3 got stb=%b expected 1101", stb_o);
    end
    step(1);
    checks++;
    if (stb_o !== 4'b0111) begin
      errors++;
      $display("FAIL sw_rst_restart4 got stb=%b expected 0111", stb_o);
    end
  endtask

  task automatic test_async_reset();
    step(5);
    #3;
    res_n = 1'b0;
    #1;
    checks++;
    if ({res_o, res_n_o, run_o, stb_o, tgl_o} !== 11'b100_0000_0000) begin
      errors++;
      $display("FAIL async_assert got res/res_n/run/stb/tgl=%b/%b/%b/%b/%b expected 1/0/0/0000/0000",
               res_o, res_n_o, run_o, stb_o, tgl_o);
    end
    step(2);
    release_and_check("rerun");
  endtask

  task automatic test_ch_enable();
    step(5);
    ch_en_i[1] = 1'b0;
    step(1);
    checks++;
    if (stb_o[1] !== 1'b0 || tgl_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL ch_disable got stb1/tgl1=%b/%b expected 0/0", stb_o[1], tgl_o[1]);
    end
    step(2);
    ch_en_i[1] = 1'b1;
    step(1);
    step(3);
    checks++;
    if (stb_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL ch_reenable3 got stb1=%b expected 0", stb_o[1]);
    end
    step(1);
    checks++;
    if (stb_o[1] !== 1'b1 || tgl_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL ch_reenable4 got stb1/tgl1=%b/%b expected 1/1", stb_o[1], tgl_o[1]);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_change();
    test_sync();
    test_sw_rst();
    test_async_reset();
    test_ch_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
